// File: rtl/mux8to1.sv
// Registered 8:1 bit multiplexer with one clock of latency and an asynchronous active-high reset.
// Define MUX8TO1_ONEHOT_EN to add a registered one-hot copy of sel on port sel_onehot.
module mux8to1 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic [7:0] data_in,
    input  logic [2:0] sel,
    output logic       mux_out,
    input  logic       clk,
    input  logic       rst
`ifdef MUX8TO1_ONEHOT_EN
    ,
    output logic [7:0] sel_onehot
`endif
);

    logic mux_d;
    logic mux_q;

    // An X/Z select matches no case item, so the register keeps its old value.
    always_comb begin
        // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
        mux_d = mux_q;
        case (sel)
            3'd0: mux_d = data_in[0];
            3'd1: mux_d = data_in[1];
            3'd2: mux_d = data_in[2];
            3'd3: mux_d = data_in[3];
            3'd4: mux_d = data_in[4];
            3'd5: mux_d = data_in[5];
            3'd6: mux_d = data_in[6];
            3'd7: mux_d = data_in[7];
            default: mux_d = mux_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mux_q <= RST_VAL;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            mux_q <= mux_d;
        end
    end

    assign mux_out = mux_q;

`ifdef MUX8TO1_ONEHOT_EN
    logic [7:0] onehot_d;
    logic [7:0] onehot_q;

    always_comb begin
        onehot_d = onehot_q;
        case (sel)
            3'd0, 3'd1, 3'd2, 3'd3,
            3'd4, 3'd5, 3'd6, 3'd7: onehot_d = 8'h01 << sel;
            default:                onehot_d = onehot_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            onehot_q <= 8'h00;
        end else begin
            onehot_q <= onehot_d;
        end
    end

    assign sel_onehot = onehot_q;
`endif

endmodule

// File: tb/tb_mux8to1.sv
// Directed self-checking bench for mux8to1; inputs change on the falling edge, outputs are sampled there too.
// Define MUX8TO1_ONEHOT_EN for both files to also exercise sel_onehot.
module tb_mux8to1;

    logic [7:0] data_in;
    logic [2:0] sel;
    logic       mux_out;
    logic       clk;
    logic       rst;
`ifdef MUX8TO1_ONEHOT_EN
    logic [7:0] sel_onehot;
`endif

    int checks = 0;
    int errors = 0;

    mux8to1 dut (
        .data_in    (data_in),
        .sel        (sel),
        .mux_out    (mux_out),
        .clk        (clk),
        .rst        (rst)
`ifdef MUX8TO1_ONEHOT_EN
        ,
        .sel_onehot (sel_onehot)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected mux_out for data_in = 8'b1010_0101 with sel = 0..7, worked out by hand.
    logic [7:0] sweep_exp = 8'b1010_0101;
    logic       exp_bit;
    logic [7:0] rnd_data;
    logic [2:0] rnd_sel;

    initial begin
        rst     = 1'b1;
        data_in = 8'hFF;
        sel     = 3'd7;

        // Reset held for two cycles with every candidate high: output stays at RST_VAL.
        @(negedge clk);
        check("reset_cycle1", {7'd0, mux_out}, 8'h00);
`ifdef MUX8TO1_ONEHOT_EN
        check("reset_onehot1", sel_onehot, 8'h00);
`endif
        @(negedge clk);
        check("reset_cycle2", {7'd0, mux_out}, 8'h00);
`ifdef MUX8TO1_ONEHOT_EN
        check("reset_onehot2", sel_onehot, 8'h00);
`endif

        // Release reset; first posedge loads data_in[7] = 1.
        rst = 1'b0;
        @(negedge clk);
        check("first_after_reset", {7'd0, mux_out}, 8'h01);

        // Sweep every select index over a fixed pattern.
        data_in = 8'b1010_0101;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            #1;
            if (i == 1) check("no_comb_path", {7'd0, mux_out}, {7'd0, sweep_exp[0]});
            @(negedge clk);
            check($sformatf("sweep_sel%0d", i), {7'd0, mux_out}, {7'd0, sweep_exp[i]});
`ifdef MUX8TO1_ONEHOT_EN
            check($sformatf("onehot_sel%0d", i), sel_onehot, 8'h01 << i);
`endif
        end

        // Adjacent selects over a single-hot word.
        data_in = 8'h80;
        sel     = 3'd7;
        @(negedge clk);
        check("h80_sel7", {7'd0, mux_out}, 8'h01);
        sel = 3'd6;
        #1;
        check("h80_sel6_hold", {7'd0, mux_out}, 8'h01);
        @(negedge clk);
        check("h80_sel6", {7'd0, mux_out}, 8'h00);

        // Asynchronous reset pulse between edges while the output is high.
        sel = 3'd7;
        @(negedge clk);
        check("pre_pulse_high", {7'd0, mux_out}, 8'h01);
        #1 rst = 1'b1;
        #1;
        check("async_reset", {7'd0, mux_out}, 8'h00);
`ifdef MUX8TO1_ONEHOT_EN
        check("async_reset_onehot", sel_onehot, 8'h00);
`endif
        #1 rst = 1'b0;
        #1;
        check("no_edge_after_release", {7'd0, mux_out}, 8'h00);
        @(negedge clk);
        check("reload_after_release", {7'd0, mux_out}, 8'h01);

        // Single-step onehot encoding for sel = 5 (data_in[5] of 8'h80 is 0).
        sel = 3'd5;
        @(negedge clk);
        check("sel5_out", {7'd0, mux_out}, 8'h00);
`ifdef MUX8TO1_ONEHOT_EN
        check("sel5_onehot", sel_onehot, 8'h20);
`endif

        // Random vectors: model value taken at the posedge, compared on the next falling edge.
        for (int n = 0; n < 100; n++) begin
            rnd_data = 8'($urandom);
            rnd_sel  = 3'($urandom_range(7, 0));
            data_in  = rnd_data;
            sel      = rnd_sel;
            @(posedge clk);
            exp_bit = rnd_data[rnd_sel];
            @(negedge clk);
            check("random", {7'd0, mux_out}, {7'd0, exp_bit});
`ifdef MUX8TO1_ONEHOT_EN
            check("random_onehot", sel_onehot, 8'h01 << rnd_sel);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
